// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and the GF(2^8) doubling helper.
package aes_pkg;

   localparam int unsigned AES_NR = 10;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned KEY_W  = 128;
   localparam int unsigned IDX_W  = 4;
   localparam logic [7:0]  RCON_INIT = 8'h01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      SUB  = 2'd2
   } state_e;

   // Round key as four 32-bit words, w0 in the most significant position.
   typedef struct packed {
      logic [WORD_W-1:0] w0;
      logic [WORD_W-1:0] w1;
      logic [WORD_W-1:0] w2;
      logic [WORD_W-1:0] w3;
   } round_key_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_key_expand_seq_s4.sv
// S4: four AES S-boxes applied bytewise to a 32-bit word, output registered (1 cycle).
module aes_key_expand_seq_s4 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] din,
   output logic [31:0] dout
);

   // Forward S-box, entry 0x00 in the top byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [31:0] dout_d;
   logic [31:0] dout_q;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TBL[{~x, 3'b000} +: 8];
   endfunction

   always_comb begin
      dout_d = '0;
      for (int i = 0; i < 4; i++) begin
         dout_d[8*i +: 8] = sbox(din[8*i +: 8]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
   end

   assign dout = dout_q;

endmodule

// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key-schedule sequencer: takes one key, streams round keys 0..10.
module aes_key_expand_seq
   import aes_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_valid,
   output logic             key_ready,
   input  logic [KEY_W-1:0] key_in,
   output logic             rk_valid,
   input  logic             rk_ready,
   output logic [KEY_W-1:0] rk_out,
   output logic [IDX_W-1:0] rk_idx,
   output logic             rk_last,
   output logic             busy
);

   if (NUM_ROUNDS != AES_NR) begin : g_bad_num_rounds
      $error("aes_key_expand_seq: only NUM_ROUNDS=10 (AES-128) is supported");
   end

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

   state_e            state_q,     state_d;
   round_key_t        key_q,       key_d;
   logic [IDX_W-1:0]  idx_q,       idx_d;
   logic [7:0]        rcon_q,      rcon_d;
   logic              rk_valid_q,  rk_valid_d;
   logic              rk_last_q,   rk_last_d;
   logic              busy_q,      busy_d;
   logic              key_ready_q, key_ready_d;

   logic [WORD_W-1:0] s4_in;
   logic [WORD_W-1:0] s4_out;
   logic [WORD_W-1:0] t;
   round_key_t        nk;

   // SubWord input is RotWord(w3), held steady by the key register through EMIT.
   assign s4_in = {key_q.w3[23:0], key_q.w3[31:24]};

   aes_key_expand_seq_s4 u_s4 (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (s4_in),
      .dout  (s4_out)
   );

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      idx_d   = idx_q;
      rcon_d  = rcon_q;
      t       = '0;
      nk      = '0;
      unique case (state_q)
         IDLE: begin
            if (key_valid && key_ready_q) begin
               key_d   = round_key_t'(key_in);
               idx_d   = '0;
               rcon_d  = RCON_INIT;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (rk_valid_q && rk_ready) begin
               state_d = (idx_q == LAST_IDX) ? IDLE : SUB;
            end
         end
         SUB: begin
            t       = s4_out ^ {rcon_q, 24'h0};
            nk.w0   = key_q.w0 ^ t;
            nk.w1   = key_q.w1 ^ nk.w0;
            nk.w2   = key_q.w2 ^ nk.w1;
            nk.w3   = key_q.w3 ^ nk.w2;
            key_d   = nk;
            idx_d   = idx_q + IDX_W'(1);
            rcon_d  = xtime(rcon_q);
            state_d = EMIT;
         end
         default: state_d = IDLE;
      endcase

      // Status outputs are registered from the next state.
      rk_valid_d  = (state_d == EMIT);
      rk_last_d   = (state_d == EMIT) && (idx_d == LAST_IDX);
      busy_d      = (state_d != IDLE);
      key_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         key_q       <= '0;
         idx_q       <= '0;
         rcon_q      <= RCON_INIT;
         rk_valid_q  <= 1'b0;
         rk_last_q   <= 1'b0;
         busy_q      <= 1'b0;
         key_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         idx_q       <= idx_d;
         rcon_q      <= rcon_d;
         rk_valid_q  <= rk_valid_d;
         rk_last_q   <= rk_last_d;
         busy_q      <= busy_d;
         key_ready_q <= key_ready_d;
      end
   end

   assign key_ready = key_ready_q;
   assign rk_valid  = rk_valid_q;
   assign rk_out    = key_q;
   assign rk_idx    = idx_q;
   assign rk_last   = rk_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: key schedule checked against a GF(2^8)-arithmetic model.
module tb_aes_key_expand_seq;

   localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         key_valid = 1'b0;
   logic         key_ready;
   logic [127:0] key_in = '0;
   logic         rk_valid;
   logic         rk_ready = 1'b0;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;
   logic         rk_last;
   logic         busy;

   aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_in    (key_in),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk_out    (rk_out),
      .rk_idx    (rk_idx),
      .rk_last   (rk_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]   sb [256];
   logic [127:0] exp_rk [11];
   logic [127:0] got_rk [11];
   logic [3:0]   got_idx [11];
   logic         got_last [11];
   int           got_cyc [11];
   int           got_n;
   int           unstable;

   // Reference S-box from its definition: multiplicative inverse then affine map.
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a = a_in;
      logic [7:0] b = b_in;
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
      logic [7:0] r = x;
      for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
      return r;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         if (v != 0) begin
            inv = 8'h01;
            for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(v));
         end
         sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   // FIPS-197 word-by-word key expansion into exp_rk.
   task automatic model(input logic [127:0] k);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
            tmp[31:24] = tmp[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Hands one key to the DUT and records every round-key handshake; no checking here.
   task automatic collect(input logic [127:0] k, input bit rand_ready);
      bit           ok = 1'b0;
      bit           hold = 1'b0;
      logic [127:0] pout = '0;
      logic [3:0]   pidx = '0;
      got_n = 0;
      unstable = 0;
      for (int i = 0; i < 11; i++) begin
         got_rk[i] = 'x; got_idx[i] = 'x; got_last[i] = 1'bx; got_cyc[i] = -1;
      end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (key_ready === 1'b1) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL collect_key_ready timeout got key_ready=%b exp 1", key_ready);
         return;
      end
      key_in = k;
      key_valid = 1'b1;
      rk_ready = 1'b1;
      for (int cyc = 1; cyc <= 400 && got_n < 11; cyc++) begin
         @(negedge clk);
         key_valid = 1'b0;
         rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (hold && (rk_valid !== 1'b1 || rk_out !== pout || rk_idx !== pidx)) unstable++;
         if (rk_valid === 1'b1 && rk_ready) begin
            got_rk[got_n] = rk_out;
            got_idx[got_n] = rk_idx;
            got_last[got_n] = rk_last;
            got_cyc[got_n] = cyc;
            got_n++;
         end
         hold = (rk_valid === 1'b1) && !rk_ready;
         pout = rk_out;
         pidx = rk_idx;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid got %b exp 0", rk_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (rk_last !== 1'b0) begin errors++; $display("FAIL reset_rk_last got %b exp 0", rk_last); end
      checks++; if (rk_idx !== 4'd0) begin errors++; $display("FAIL reset_rk_idx got %0d exp 0", rk_idx); end
      checks++; if (rk_out !== 128'h0) begin errors++; $display("FAIL reset_rk_out got %h exp 0", rk_out); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b exp 1", key_ready); end
   endtask

   task automatic test_fips();
      model(FIPS_KEY);
      collect(FIPS_KEY, 1'b0);
      checks++; if (got_n != 11) begin errors++; $display("FAIL fips_count got %0d exp 11", got_n); end
      checks++; if (got_rk[0] !== FIPS_KEY) begin errors++; $display("FAIL fips_rk0 got %h exp %h", got_rk[0], FIPS_KEY); end
      checks++; if (got_rk[1] !== FIPS_RK1) begin errors++; $display("FAIL fips_rk1 got %h exp %h", got_rk[1], FIPS_RK1); end
      checks++; if (got_rk[10] !== FIPS_RK10) begin errors++; $display("FAIL fips_rk10 got %h exp %h", got_rk[10], FIPS_RK10); end
      for (int i = 0; i < 11; i++) begin
         checks++; if (got_rk[i] !== exp_rk[i]) begin errors++; $display("FAIL fips_model rk%0d got %h exp %h", i, got_rk[i], exp_rk[i]); end
         checks++; if (got_idx[i] !== 4'(i)) begin errors++; $display("FAIL fips_idx n%0d got %0d exp %0d", i, got_idx[i], i); end
         checks++; if (got_last[i] !== (i == 10)) begin errors++; $display("FAIL fips_last n%0d got %b exp %b", i, got_last[i], i == 10); end
         checks++; if (got_cyc[i] != 2*i + 1) begin errors++; $display("FAIL fips_cycle rk%0d got %0d exp %0d", i, got_cyc[i], 2*i + 1); end
      end
      @(negedge clk);
      checks++; if (key_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fips_idle_after got ready=%b busy=%b exp 1 0", key_ready, busy); end
   endtask

   task automatic test_zero();
      model(128'h0);
      collect(128'h0, 1'b0);
      checks++; if (got_rk[1] !== ZERO_RK1) begin errors++; $display("FAIL zero_rk1 got %h exp %h", got_rk[1], ZERO_RK1); end
      checks++; if (got_rk[10] !== ZERO_RK10) begin errors++; $display("FAIL zero_rk10 got %h exp %h", got_rk[10], ZERO_RK10); end
      for (int i = 0; i < 11; i++) begin
         checks++; if (got_rk[i] !== exp_rk[i]) begin errors++; $display("FAIL zero_model rk%0d got %h exp %h", i, got_rk[i], exp_rk[i]); end
      end
   endtask

   task automatic test_backpressure();
      model(FIPS_KEY);
      collect(FIPS_KEY, 1'b1);
      checks++; if (got_n != 11) begin errors++; $display("FAIL bp_count got %0d exp 11", got_n); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", unstable); end
      for (int i = 0; i < 11; i++) begin
         checks++; if (got_rk[i] !== exp_rk[i] || got_idx[i] !== 4'(i)) begin
            errors++; $display("FAIL bp_seq n%0d got %h/%0d exp %h/%0d", i, got_rk[i], got_idx[i], exp_rk[i], i);
         end
      end
   endtask

   task automatic test_random_keys();
      logic [127:0] k;
      for (int n = 0; n < 3; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         model(k);
         collect(k, 1'b1);
         checks++; if (unstable != 0) begin errors++; $display("FAIL rand_stable key%0d got %0d exp 0", n, unstable); end
         for (int i = 0; i < 11; i++) begin
            checks++; if (got_rk[i] !== exp_rk[i] || got_idx[i] !== 4'(i)) begin
               errors++; $display("FAIL rand_seq key%0d n%0d got %h/%0d exp %h/%0d", n, i, got_rk[i], got_idx[i], exp_rk[i], i);
            end
         end
      end
   endtask

   task automatic test_hold_valid();
      logic [127:0] kb = {$urandom, $urandom, $urandom, $urandom};
      bit ok = 1'b0;
      model(kb);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (key_ready === 1'b1) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL hold_start timeout got key_ready=%b exp 1", key_ready); end
      key_in = FIPS_KEY;
      key_valid = 1'b1;
      rk_ready = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         @(negedge clk);
         checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL hold_key_ready cycle %0d got %b exp 0", c, key_ready); end
      end
      checks++; if (rk_valid !== 1'b1 || rk_idx !== 4'd10 || rk_last !== 1'b1) begin
         errors++; $display("FAIL hold_rk10 got v=%b idx=%0d last=%b exp 1 10 1", rk_valid, rk_idx, rk_last);
      end
      key_in = kb;
      @(negedge clk);
      checks++; if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin errors++; $display("FAIL hold_c22 got ready=%b valid=%b exp 1 0", key_ready, rk_valid); end
      for (int c = 23; c <= 43; c++) begin
         @(negedge clk);
         key_valid = 1'b0;
         if (c % 2 == 1) begin
            checks++; if (rk_valid !== 1'b1 || rk_out !== exp_rk[(c-23)/2] || rk_idx !== 4'((c-23)/2)) begin
               errors++; $display("FAIL hold_second cycle %0d got v=%b %h/%0d exp 1 %h/%0d", c, rk_valid, rk_out, rk_idx, exp_rk[(c-23)/2], (c-23)/2);
            end
         end
      end
      @(negedge clk);
      checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL hold_end_ready got %b exp 1", key_ready); end
   endtask

   task automatic test_reset_mid();
      logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
      bit ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (key_ready === 1'b1) break;
      end
      key_in = FIPS_KEY;
      key_valid = 1'b1;
      rk_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         key_valid = 1'b0;
         if (rk_valid === 1'b1 && rk_idx === 4'd5) begin rk_ready = 1'b0; ok = 1'b1; break; end
      end
      repeat (3) @(negedge clk);
      checks++; if (!ok || rk_valid !== 1'b1 || rk_idx !== 4'd5) begin errors++; $display("FAIL mid_wait got v=%b idx=%0d exp 1 5", rk_valid, rk_idx); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", rk_valid); end
      checks++; if (busy !== 1'b0 || key_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_status got busy=%b ready=%b exp 0 1", busy, key_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      model(k);
      collect(k, 1'b0);
      checks++; if (got_cyc[0] != 1) begin errors++; $display("FAIL mid_restart_latency got %0d exp 1", got_cyc[0]); end
      for (int i = 0; i < 11; i++) begin
         checks++; if (got_rk[i] !== exp_rk[i] || got_idx[i] !== 4'(i)) begin
            errors++; $display("FAIL mid_restart n%0d got %h/%0d exp %h/%0d", i, got_rk[i], got_idx[i], exp_rk[i], i);
         end
      end
   endtask

   task automatic test_back_to_back();
      model(FIPS_KEY);
      collect(FIPS_KEY, 1'b0);
      checks++; if (got_rk[10] !== exp_rk[10]) begin errors++; $display("FAIL b2b_first_rk10 got %h exp %h", got_rk[10], exp_rk[10]); end
      model(128'h0);
      collect(128'h0, 1'b0);
      checks++; if (got_rk[1] !== ZERO_RK1) begin errors++; $display("FAIL b2b_zero_rk1 got %h exp %h", got_rk[1], ZERO_RK1); end
      checks++; if (got_rk[10] !== ZERO_RK10 || got_last[10] !== 1'b1) begin
         errors++; $display("FAIL b2b_zero_rk10 got %h last=%b exp %h 1", got_rk[10], got_last[10], ZERO_RK10);
      end
      for (int i = 0; i < 11; i++) begin
         checks++; if (got_rk[i] !== exp_rk[i] || got_idx[i] !== 4'(i)) begin
            errors++; $display("FAIL b2b_zero n%0d got %h/%0d exp %h/%0d", i, got_rk[i], got_idx[i], exp_rk[i], i);
         end
      end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_fips();
      test_zero();
      test_backpressure();
      test_random_keys();
      test_hold_valid();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
